m0ds_lite_core: RTL and testbench
=================================

Name: m0ds_lite_core

Overview:
- Reduced Cortex-M0-compatible AHB-Lite master core: the drop-in processor macro cell of the DesignStart subsystem, with the CORTEXM0DS port list.
- Runs the ARMv6-M reset sequence, then executes a small subset of 16-bit Thumb instructions from zero-wait or wait-stated AHB memory.
- Unsupported encodings halt the core in LOCKUP.

Parameters:
- RESET_ADDR, 32'h0000_0000, base of the vector table (initial SP at +0, reset PC at +4).

Ports:
- HCLK in 1: single clock, all logic on the rising edge.
- HRESETn in 1: reset, synchronous, active-high (asserted = 1).
- HADDR out 32: AHB byte address.
- HBURST out 3: tied 3'b000.
- HMASTLOCK out 1: tied 0.
- HPROT out 4: 4'b0010 on instruction fetch, 4'b0011 on data access.
- HSIZE out 3: 0 = byte, 2 = word.
- HTRANS out 2: 2'b00 IDLE or 2'b10 NONSEQ only.
- HWDATA out 32: write data.
- HWRITE out 1: 1 = write.
- HRDATA in 32: read data.
- HREADY in 1: transfer done / stall.
- HRESP in 1: error response.
- NMI in 1, IRQ in 16, RXEV in 1: ignored.
- TXEV out 1: one-cycle pulse when SEV executes.
- LOCKUP out 1: core halted.
- SYSRESETREQ out 1: tied 0.
- SLEEPING out 1: tied 0.

Behaviour:
- Reset values: all outputs 0; R0-R7, SP, PC and flags N, Z, C cleared; state = VEC_SP_A.
- Bus timing follows AHB-Lite: address phase then data phase.
  - A phase advances only on an edge with HREADY = 1.
  - While HREADY = 0, all address- and data-phase outputs hold.
- State machine, one non-pipelined transfer at a time; HTRANS = NONSEQ only in *_A states, IDLE otherwise:
  - VEC_SP_A: HADDR = RESET_ADDR, word read. Next VEC_SP_D.
  - VEC_SP_D: SP <= HRDATA. Next VEC_PC_A.
  - VEC_PC_A: HADDR = RESET_ADDR + 4. Next VEC_PC_D.
  - VEC_PC_D: if HRDATA[0] = 0, go to LOCK. Otherwise PC <= HRDATA & ~1, next FETCH_A.
  - FETCH_A: HADDR = PC & ~3, word read. Next FETCH_D.
  - FETCH_D: instruction = PC[1] ? HRDATA[31:16] : HRDATA[15:0]. Decode and execute the same cycle; loads/stores go to MEM_A, others to FETCH_A.
  - MEM_A: HADDR = effective address, HSIZE = 2 (word) or 0 (byte), HWRITE = store. Next MEM_D.
  - MEM_D: loads write Rt; stores drive HWDATA. Next FETCH_A.
  - LOCK: LOCKUP = 1, HTRANS = IDLE. Left only by reset.
- Latency: plain instruction 2 cycles; load/store 4 cycles; plus wait states.
- PC: "PC operand" = instruction address + 4. Non-branch instructions do PC += 2.
- Instruction subset (Rd/Rt/Rn/Rm are 3-bit):
  - 00100 Rd imm8: MOVS. NZ updated, C unchanged.
  - 00101 Rd imm8: CMP. NZC from Rd - imm8; C = no borrow.
  - 00110: ADDS. NZC updated, 32-bit wrap.
  - 00111: SUBS. NZC updated.
  - 00000 imm5 Rm Rd: LSLS. imm5 = 0 is MOVS Rd,Rm (NZ only); else C = last bit shifted out.
  - 01100 imm5 Rn Rt: STR, address Rn + imm5*4.
  - 01101: LDR, same address rule.
  - 01110: STRB, address Rn + imm5.
  - 01111: LDRB, zero-extended.
  - 11100 imm11: B. PC <= PC operand + sext(imm11)<<1.
  - 1101 cond imm8: cond 0000 EQ (Z = 1), 0001 NE (Z = 0). Taken: PC <= PC operand + sext(imm8)<<1; not taken: PC += 2.
  - 0xBF00: NOP.
  - 0xBF40: SEV, TXEV = 1 for exactly the next cycle.
  - Any other encoding goes to LOCK. PC keeps the faulting address.
- Data lanes:
  - STR drives Rt on HWDATA.
  - STRB replicates Rt[7:0] on all four byte lanes.
  - LDRB selects the HRDATA byte by address[1:0], little-endian.
- Misaligned LDR/STR (address[1:0] != 0) goes to LOCK before issuing the address phase; no bus transfer occurs.
- Reset asserted in any state (mid-transfer included) returns to VEC_SP_A on the next edge; outputs go to reset values.

Optional Feature:
- Macro M0LITE_HRESP_LOCKUP_EN.
- Defined: HRESP = 1 sampled in any *_D state with HREADY = 1 goes to LOCK, and the read data/write is discarded.
- Undefined: HRESP is ignored.

Test Plan:
- Vectors word0 = 0x2000_1000, word1 = 0x0000_0101, HREADY = 1; release reset → reads at 0x0, 0x4, then fetch at 0x100; SP = 0x2000_1000.
- Program MOVS r0,#0x41 / LDR-base r1 = 0x4000_0000 built via MOVS+LSLS / STRB r0,[r1] → write cycle HADDR 0x4000_0000, HSIZE = 0, HWDATA = 0x4141_4141.
- STR r2 = 0xFF to 0x200 then LDR r3 from 0x200 → memory word 0x0000_00FF; r3 = 0xFF, then CMP r3,#0xFF / BEQ taken, landing at its target.
- Insert HREADY = 0 for 3 cycles during a fetch address phase → HADDR/HTRANS held; instruction executes once.
- SEV (0xBF40) → TXEV high exactly one cycle. Then 0xDE00 → LOCKUP = 1, HTRANS = IDLE persistent until reset.
- Vector word1 = 0x0000_0100 (bit0 = 0) → LOCKUP after the second vector read; no instruction fetch issued.

Source files
------------

// File: rtl/m0ds_lite_core_if.sv
// AHB-Lite bus bundle between the m0ds_lite_core master and the memory system.
// The master drives the address/control/write-data, the slave returns read data,
// ready and response.
interface m0ds_lite_core_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/m0ds_lite_core.sv
// m0ds_lite_core: reduced Cortex-M0 style AHB-Lite master. Runs the vector
// fetch (SP, then PC), then executes a small Thumb subset one non-pipelined
// bus transfer at a time. Anything it cannot execute parks it in LOCK.
// Optional build macro: M0LITE_HRESP_LOCKUP_EN - an error response on any
// completed data phase sends the core to LOCK and discards the transfer.
module m0ds_lite_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    m0ds_lite_core_if.master ahb,
    input  logic             NMI,
    input  logic [15:0]      IRQ,
    input  logic             RXEV,
    output logic             TXEV,
    output logic             LOCKUP,
    output logic             SYSRESETREQ,
    output logic             SLEEPING
);
    typedef enum logic [3:0] {
        VEC_SP_A, VEC_SP_D, VEC_PC_A, VEC_PC_D,
        FETCH_A, FETCH_D, MEM_A, MEM_D, LOCK
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [3:0] PROT_INSTR   = 4'b0010;
    localparam logic [3:0] PROT_DATA    = 4'b0011;
    localparam logic [2:0] SIZE_BYTE    = 3'd0;
    localparam logic [2:0] SIZE_WORD    = 3'd2;

    // Little-endian byte lane pick for LDRB.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r;
    logic [31:0] regs_r [0:7];
    logic [31:0] sp_r;
    logic [31:0] pc_r;
    logic        n_r, z_r, c_r;
    logic [31:0] haddr_r, hwdata_r;
    logic [1:0]  htrans_r;
    logic [2:0]  hsize_r;
    logic [3:0]  hprot_r;
    logic        hwrite_r, txev_r, lockup_r;
    logic [2:0]  mem_rt_r;
    logic [1:0]  mem_lane_r;
    logic        mem_load_r, mem_byte_r;

    logic        bus_err_s;
    logic [15:0] instr_s;
    logic [31:0] rd_val_s, rm_val_s, imm8_s, pc_op_s, res_s, pc_next_s, ea_s;
    logic [32:0] add_s, sub_s, shl_s;
    logic [2:0]  wr_idx_s;
    logic        wr_en_s, upd_nz_s, upd_c_s, c_new_s;
    logic        mem_op_s, mem_load_s, mem_byte_s, lock_s, sev_s;
    logic        unused_inputs_s;

`ifdef M0LITE_HRESP_LOCKUP_EN
    assign bus_err_s = ahb.HRESP;
`else
    assign bus_err_s = 1'b0;
`endif

    // Inputs the core does not act on (and SP, which nothing reads back yet).
    assign unused_inputs_s = ^{NMI, IRQ, RXEV, ahb.HRESP, sp_r};

    assign ahb.HADDR     = haddr_r;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = hprot_r;
    assign ahb.HSIZE     = hsize_r;
    assign ahb.HTRANS    = htrans_r;
    assign ahb.HWDATA    = hwdata_r;
    assign ahb.HWRITE    = hwrite_r;
    assign TXEV          = txev_r;
    assign LOCKUP        = lockup_r;
    assign SYSRESETREQ   = 1'b0;
    assign SLEEPING      = 1'b0;

    // Decode/execute of the halfword currently on the fetch data phase.
    always_comb begin
        instr_s    = pc_r[1] ? ahb.HRDATA[31:16] : ahb.HRDATA[15:0];
        rd_val_s   = regs_r[instr_s[10:8]];
        rm_val_s   = regs_r[instr_s[5:3]];
        imm8_s     = {24'h00_0000, instr_s[7:0]};
        add_s      = {1'b0, rd_val_s} + {1'b0, imm8_s};
        sub_s      = {1'b0, rd_val_s} - {1'b0, imm8_s};
        shl_s      = {1'b0, rm_val_s} << instr_s[10:6];
        pc_op_s    = pc_r + 32'd4;
        res_s      = 32'h0000_0000;
        wr_en_s    = 1'b0;
        wr_idx_s   = instr_s[10:8];
        upd_nz_s   = 1'b0;
        upd_c_s    = 1'b0;
        c_new_s    = c_r;
        pc_next_s  = pc_r + 32'd2;
        mem_op_s   = 1'b0;
        mem_load_s = 1'b0;
        mem_byte_s = 1'b0;
        ea_s       = 32'h0000_0000;
        lock_s     = 1'b0;
        sev_s      = 1'b0;
        case (instr_s[15:11])
            5'b00100: begin
                res_s = imm8_s; wr_en_s = 1'b1; upd_nz_s = 1'b1;
            end
            5'b00101: begin
                res_s = sub_s[31:0]; upd_nz_s = 1'b1; upd_c_s = 1'b1; c_new_s = ~sub_s[32];
            end
            5'b00110: begin
                res_s = add_s[31:0]; wr_en_s = 1'b1; upd_nz_s = 1'b1; upd_c_s = 1'b1; c_new_s = add_s[32];
            end
            5'b00111: begin
                res_s = sub_s[31:0]; wr_en_s = 1'b1; upd_nz_s = 1'b1; upd_c_s = 1'b1; c_new_s = ~sub_s[32];
            end
            5'b00000: begin
                res_s = shl_s[31:0]; wr_en_s = 1'b1; wr_idx_s = instr_s[2:0]; upd_nz_s = 1'b1;
                if (instr_s[10:6] != 5'd0) begin
                    upd_c_s = 1'b1; c_new_s = shl_s[32];
                end else begin
                    upd_c_s = 1'b0;
                end
            end
            5'b01100, 5'b01101: begin
                ea_s = rm_val_s + {25'h000_0000, instr_s[10:6], 2'b00};
                if (ea_s[1:0] != 2'b00) begin
                    lock_s = 1'b1;
                end else begin
                    mem_op_s = 1'b1; mem_load_s = instr_s[11];
                end
            end
            5'b01110, 5'b01111: begin
                ea_s = rm_val_s + {27'h000_0000, instr_s[10:6]};
                mem_op_s = 1'b1; mem_byte_s = 1'b1; mem_load_s = instr_s[11];
            end
            5'b11100: begin
                pc_next_s = pc_op_s + {{20{instr_s[10]}}, instr_s[10:0], 1'b0};
            end
            5'b11010, 5'b11011: begin
                case (instr_s[11:8])
                    4'h0: begin
                        if (z_r) pc_next_s = pc_op_s + {{23{instr_s[7]}}, instr_s[7:0], 1'b0};
                        else     pc_next_s = pc_r + 32'd2;
                    end
                    4'h1: begin
                        if (!z_r) pc_next_s = pc_op_s + {{23{instr_s[7]}}, instr_s[7:0], 1'b0};
                        else      pc_next_s = pc_r + 32'd2;
                    end
                    default: lock_s = 1'b1;
                endcase
            end
            5'b10111: begin
                if (instr_s == 16'hBF00)      sev_s = 1'b0;
                else if (instr_s == 16'hBF40) sev_s = 1'b1;
                else                          lock_s = 1'b1;
            end
            default: lock_s = 1'b1;
        endcase
    end

    // Bus sequencer and architectural state; nothing advances without HREADY.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_r    <= VEC_SP_A;
            for (int i = 0; i < 8; i++) regs_r[i] <= 32'h0000_0000;
            sp_r       <= 32'h0000_0000;
            pc_r       <= 32'h0000_0000;
            n_r        <= 1'b0;
            z_r        <= 1'b0;
            c_r        <= 1'b0;
            haddr_r    <= 32'h0000_0000;
            hwdata_r   <= 32'h0000_0000;
            htrans_r   <= TRANS_IDLE;
            hsize_r    <= 3'd0;
            hprot_r    <= 4'h0;
            hwrite_r   <= 1'b0;
            txev_r     <= 1'b0;
            lockup_r   <= 1'b0;
            mem_rt_r   <= 3'd0;
            mem_lane_r <= 2'd0;
            mem_load_r <= 1'b0;
            mem_byte_r <= 1'b0;
        end else begin
            txev_r <= 1'b0;
            case (state_r)
                VEC_SP_A: begin
                    // First cycle out of reset the bus is still idle: launch the SP read.
                    if (htrans_r == TRANS_IDLE) begin
                        haddr_r <= RESET_ADDR; htrans_r <= TRANS_NONSEQ;
                        hsize_r <= SIZE_WORD; hwrite_r <= 1'b0; hprot_r <= PROT_DATA;
                    end else if (ahb.HREADY) begin
                        htrans_r <= TRANS_IDLE; state_r <= VEC_SP_D;
                    end
                end
                VEC_SP_D: if (ahb.HREADY) begin
                    if (bus_err_s) begin
                        state_r <= LOCK; lockup_r <= 1'b1;
                    end else begin
                        sp_r    <= ahb.HRDATA;
                        haddr_r <= RESET_ADDR + 32'd4; htrans_r <= TRANS_NONSEQ;
                        hsize_r <= SIZE_WORD; hwrite_r <= 1'b0; hprot_r <= PROT_DATA;
                        state_r <= VEC_PC_A;
                    end
                end
                VEC_PC_A: if (ahb.HREADY) begin
                    htrans_r <= TRANS_IDLE; state_r <= VEC_PC_D;
                end
                VEC_PC_D: if (ahb.HREADY) begin
                    // A reset vector without the Thumb bit is unusable.
                    if (bus_err_s || !ahb.HRDATA[0]) begin
                        state_r <= LOCK; lockup_r <= 1'b1;
                    end else begin
                        pc_r    <= {ahb.HRDATA[31:1], 1'b0};
                        haddr_r <= {ahb.HRDATA[31:2], 2'b00}; htrans_r <= TRANS_NONSEQ;
                        hsize_r <= SIZE_WORD; hwrite_r <= 1'b0; hprot_r <= PROT_INSTR;
                        state_r <= FETCH_A;
                    end
                end
                FETCH_A: if (ahb.HREADY) begin
                    htrans_r <= TRANS_IDLE; state_r <= FETCH_D;
                end
                FETCH_D: if (ahb.HREADY) begin
                    // Faulting instructions leave PC pointing at themselves.
                    if (bus_err_s || lock_s) begin
                        state_r <= LOCK; lockup_r <= 1'b1;
                    end else begin
                        if (wr_en_s) regs_r[wr_idx_s] <= res_s;
                        if (upd_nz_s) begin
                            n_r <= res_s[31]; z_r <= (res_s == 32'h0000_0000);
                        end
                        if (upd_c_s) c_r <= c_new_s;
                        txev_r <= sev_s;
                        pc_r   <= pc_next_s;
                        if (mem_op_s) begin
                            haddr_r    <= ea_s; htrans_r <= TRANS_NONSEQ;
                            hsize_r    <= mem_byte_s ? SIZE_BYTE : SIZE_WORD;
                            hwrite_r   <= ~mem_load_s; hprot_r <= PROT_DATA;
                            mem_rt_r   <= instr_s[2:0]; mem_lane_r <= ea_s[1:0];
                            mem_load_r <= mem_load_s; mem_byte_r <= mem_byte_s;
                            state_r    <= MEM_A;
                        end else begin
                            haddr_r <= {pc_next_s[31:2], 2'b00}; htrans_r <= TRANS_NONSEQ;
                            hsize_r <= SIZE_WORD; hwrite_r <= 1'b0; hprot_r <= PROT_INSTR;
                            state_r <= FETCH_A;
                        end
                    end
                end
                MEM_A: if (ahb.HREADY) begin
                    htrans_r <= TRANS_IDLE; state_r <= MEM_D;
                    // Byte stores replicate the byte so any lane the slave picks is right.
                    if (!mem_load_r) begin
                        hwdata_r <= mem_byte_r ? {4{regs_r[mem_rt_r][7:0]}} : regs_r[mem_rt_r];
                    end
                end
                MEM_D: if (ahb.HREADY) begin
                    if (bus_err_s) begin
                        state_r <= LOCK; lockup_r <= 1'b1;
                    end else begin
                        if (mem_load_r) begin
                            regs_r[mem_rt_r] <= mem_byte_r ?
                                {24'h00_0000, select_byte(ahb.HRDATA, mem_lane_r)} : ahb.HRDATA;
                        end
                        haddr_r <= {pc_r[31:2], 2'b00}; htrans_r <= TRANS_NONSEQ;
                        hsize_r <= SIZE_WORD; hwrite_r <= 1'b0; hprot_r <= PROT_INSTR;
                        state_r <= FETCH_A;
                    end
                end
                LOCK: begin
                    htrans_r <= TRANS_IDLE; lockup_r <= 1'b1;
                end
                default: begin
                    state_r <= LOCK; htrans_r <= TRANS_IDLE; lockup_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_m0ds_lite_core.sv
// Directed bench for m0ds_lite_core: a zero-wait AHB memory model, a short
// Thumb program exercising stores, loads, branches, a fetch stall and SEV,
// then a bad reset vector.
module tb_m0ds_lite_core;
    logic        HCLK;
    logic        HRESETn;
    logic        NMI, RXEV, TXEV, LOCKUP, SYSRESETREQ, SLEEPING;
    logic [15:0] IRQ;

    m0ds_lite_core_if bus();

    m0ds_lite_core dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
        .NMI(NMI), .IRQ(IRQ), .RXEV(RXEV), .TXEV(TXEV), .LOCKUP(LOCKUP),
        .SYSRESETREQ(SYSRESETREQ), .SLEEPING(SLEEPING)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    logic [31:0] init_mem [0:255];
    logic [31:0] mem [0:255];
    logic        pend_v, pend_w;
    logic [31:0] pend_a;
    logic [2:0]  pend_sz;
    logic [31:0] xfer_addr [0:63];
    int          xfer_n, f11c_cnt, io_cnt, txev_cnt;
    logic [31:0] io_addr, io_data;
    logic [2:0]  io_size;
    logic        stall_seen;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put_hw(input logic [31:0] addr, input logic [15:0] hw);
        if (addr[1]) init_mem[addr[9:2]][31:16] = hw;
        else         init_mem[addr[9:2]][15:0]  = hw;
    endtask

    // AHB slave: memory below 0x400, writes elsewhere land in a one-entry log.
    always @(posedge HCLK) begin
        if (HRESETn) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            pend_v <= 1'b0; pend_w <= 1'b0; pend_a <= 32'h0; pend_sz <= 3'd0;
            bus.HRDATA <= 32'h0;
            xfer_n <= 0; f11c_cnt <= 0; io_cnt <= 0;
            io_addr <= 32'h0; io_data <= 32'h0; io_size <= 3'd7;
        end else if (bus.HREADY) begin
            if (pend_v && pend_w) begin
                if (pend_a[31:10] == 22'h0) begin
                    if (pend_sz == 3'd0)
                        mem[pend_a[9:2]][{pend_a[1:0], 3'b000} +: 8] <= bus.HWDATA[{pend_a[1:0], 3'b000} +: 8];
                    else
                        mem[pend_a[9:2]] <= bus.HWDATA;
                end else begin
                    io_addr <= pend_a; io_size <= pend_sz; io_data <= bus.HWDATA; io_cnt <= io_cnt + 1;
                end
            end
            pend_v  <= (bus.HTRANS == 2'b10);
            pend_a  <= bus.HADDR;
            pend_w  <= bus.HWRITE;
            pend_sz <= bus.HSIZE;
            if (bus.HTRANS == 2'b10) begin
                if (xfer_n < 64) xfer_addr[xfer_n] <= bus.HADDR;
                xfer_n <= xfer_n + 1;
                if (bus.HADDR == 32'h0000_011C && bus.HPROT == 4'b0010) f11c_cnt <= f11c_cnt + 1;
                if (!bus.HWRITE)
                    bus.HRDATA <= (bus.HADDR[31:10] == 22'h0) ? mem[bus.HADDR[9:2]] : 32'h0;
            end
        end
    end

    // Count cycles with TXEV high.
    always @(negedge HCLK) begin
        if (HRESETn) txev_cnt <= 0;
        else if (TXEV === 1'b1) txev_cnt <= txev_cnt + 1;
    end

    initial begin
        HRESETn = 1'b1; NMI = 1'b0; IRQ = 16'h0; RXEV = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        stall_seen = 1'b0;
        for (int i = 0; i < 256; i++) init_mem[i] = 32'h0;
        init_mem[0]    = 32'h2000_1000;
        init_mem[1]    = 32'h0000_0101;
        init_mem[8'hC0] = 32'h1122_3344;
        put_hw(32'h100, 16'h2041); put_hw(32'h102, 16'h2140); put_hw(32'h104, 16'h0609);
        put_hw(32'h106, 16'h7008); put_hw(32'h108, 16'h22FF); put_hw(32'h10A, 16'h2480);
        put_hw(32'h10C, 16'h00A4); put_hw(32'h10E, 16'h6022); put_hw(32'h110, 16'h6823);
        put_hw(32'h112, 16'h2BFF); put_hw(32'h114, 16'hD000); put_hw(32'h116, 16'hDE01);
        put_hw(32'h118, 16'h6063); put_hw(32'h11A, 16'h2500); put_hw(32'h11C, 16'h3501);
        put_hw(32'h11E, 16'h60A5); put_hw(32'h120, 16'h26C0); put_hw(32'h122, 16'h00B6);
        put_hw(32'h124, 16'h7877); put_hw(32'h126, 16'h6127); put_hw(32'h128, 16'h3F33);
        put_hw(32'h12A, 16'hD100); put_hw(32'h12C, 16'h2709); put_hw(32'h12E, 16'h6167);
        put_hw(32'h130, 16'hBF40); put_hw(32'h132, 16'hBF00); put_hw(32'h134, 16'hDE00);

        repeat (3) @(negedge HCLK);
        check32("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
        check32("rst_haddr", bus.HADDR, 32'h0);
        check32("rst_hwrite", {31'h0, bus.HWRITE}, 32'h0);
        check32("rst_hwdata", bus.HWDATA, 32'h0);
        check32("rst_lockup", {31'h0, LOCKUP}, 32'h0);
        check32("rst_txev", {31'h0, TXEV}, 32'h0);

        HRESETn = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge HCLK);
            if (LOCKUP === 1'b1) break;
            if (!stall_seen && bus.HTRANS == 2'b10 && bus.HADDR == 32'h0000_011C) begin
                stall_seen = 1'b1;
                bus.HREADY = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge HCLK);
                    check32("stall_haddr", bus.HADDR, 32'h0000_011C);
                    check32("stall_htrans", {30'h0, bus.HTRANS}, 32'h2);
                end
                bus.HREADY = 1'b1;
            end
        end
        check32("prog_lockup", {31'h0, LOCKUP}, 32'h1);
        check32("vec_addr0", xfer_addr[0], 32'h0000_0000);
        check32("vec_addr1", xfer_addr[1], 32'h0000_0004);
        check32("first_fetch", xfer_addr[2], 32'h0000_0100);
        check32("sp_loaded", dut.sp_r, 32'h2000_1000);
        check32("strb_count", io_cnt, 32'd1);
        check32("strb_addr", io_addr, 32'h4000_0000);
        check32("strb_size", {29'h0, io_size}, 32'h0);
        check32("strb_data", io_data, 32'h4141_4141);
        check32("str_word", mem[8'h80], 32'h0000_00FF);
        check32("ldr_beq", mem[8'h81], 32'h0000_00FF);
        check32("stall_once", mem[8'h82], 32'h0000_0001);
        check32("stall_seen", {31'h0, stall_seen}, 32'h1);
        check32("fetch_11c", f11c_cnt, 32'd2);
        check32("ldrb_lane1", mem[8'h84], 32'h0000_0033);
        check32("bne_not_taken", mem[8'h85], 32'h0000_0009);
        check32("txev_cycles", txev_cnt, 32'd1);
        check32("lock_pc", dut.pc_r, 32'h0000_0134);
        repeat (5) @(negedge HCLK);
        check32("lock_persist", {31'h0, LOCKUP}, 32'h1);
        check32("lock_idle", {30'h0, bus.HTRANS}, 32'h0);

        // Reset vector without the Thumb bit.
        init_mem[1] = 32'h0000_0100;
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        check32("rst2_lockup", {31'h0, LOCKUP}, 32'h0);
        HRESETn = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge HCLK);
            if (LOCKUP === 1'b1) break;
        end
        check32("badvec_lockup", {31'h0, LOCKUP}, 32'h1);
        repeat (3) @(negedge HCLK);
        check32("badvec_xfers", xfer_n, 32'd2);
        check32("badvec_idle", {30'h0, bus.HTRANS}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
